// File: rtl/imul_share_arbiter_pkg.sv
// Shared definitions for the two-client integer multiplier arbiter:
// FSM encodings and the {a, b} operand message layout used by the multiplier.
package imul_share_arbiter_pkg;

  localparam int P_NBITS = 32;

  // Two bits wide so that illegal encodings exist and recover to IDLE
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_WAIT = 2'd1;

  typedef struct packed {
    logic [P_NBITS-1:0] a;
    logic [P_NBITS-1:0] b;
  } imul_req_msg_t;

endpackage

// File: rtl/imul_share_arbiter_if.sv
// Generic val/rdy channel carrying a W-bit message; master drives val/msg,
// slave drives rdy.
interface imul_share_arbiter_if #(
  parameter int W = 32
);

  logic         val;
  logic         rdy;
  logic [W-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);

endinterface

// File: rtl/imul_share_arbiter_rr_arb2.sv
// Two-input round-robin grant: the favoured input wins a tie, a lone
// requester always wins.
module imul_rr_arb2 (
  input  logic [1:0] val,
  input  logic       prio,
  output logic       grant_val,
  output logic       grant_idx
);

  always_comb begin
    grant_val = |val;
    grant_idx = val[prio] ? prio : ~prio;
  end

endmodule

// File: rtl/imul_share_arbiter.sv
// Shares one iterative multiplier between two val/rdy requesters, one
// transaction in flight, round-robin on ties, zero added latency.
module imul_share_arbiter
  import imul_share_arbiter_pkg::*;
#(
  parameter int p_nbits = P_NBITS
) (
  input  logic                 clk,
  input  logic                 reset,
  imul_share_arbiter_if.slave  req0,
  imul_share_arbiter_if.master resp0,
  imul_share_arbiter_if.slave  req1,
  imul_share_arbiter_if.master resp1,
  imul_share_arbiter_if.master mul_req,
  imul_share_arbiter_if.slave  mul_resp
);

  logic [1:0]           state_reg;
  logic                 owner_reg;
  logic                 prio_reg;

  logic                 grant_val;
  logic                 grant_idx;
  logic                 owner_rdy;
  logic                 req_fire;
  logic                 resp_fire;

  logic                 req0_rdy_c;
  logic                 req1_rdy_c;
  logic                 mul_req_val_c;
  logic [2*p_nbits-1:0] mul_req_msg_c;
  logic                 resp0_val_c;
  logic                 resp1_val_c;
  logic [p_nbits-1:0]   resp0_msg_c;
  logic [p_nbits-1:0]   resp1_msg_c;
  logic                 mul_resp_rdy_c;

  imul_rr_arb2 u_arb (
    .val       ({req1.val, req0.val}),
    .prio      (prio_reg),
    .grant_val (grant_val),
    .grant_idx (grant_idx)
  );

  always_comb begin
    owner_rdy = owner_reg ? resp1.rdy : resp0.rdy;
    req_fire  = (state_reg == STATE_IDLE) && grant_val && mul_req.rdy;
    resp_fire = (state_reg == STATE_WAIT) && mul_resp.val && owner_rdy;
  end

  always_comb begin
    req0_rdy_c     = 1'b0;
    req1_rdy_c     = 1'b0;
    mul_req_val_c  = 1'b0;
    mul_req_msg_c  = '0;
    resp0_val_c    = 1'b0;
    resp1_val_c    = 1'b0;
    resp0_msg_c    = '0;
    resp1_msg_c    = '0;
    mul_resp_rdy_c = 1'b0;
    case (state_reg)
      STATE_IDLE: begin
        mul_req_val_c = grant_val;
        if (grant_val)
          mul_req_msg_c = grant_idx ? req1.msg : req0.msg;
        req0_rdy_c = grant_val && !grant_idx && mul_req.rdy;
        req1_rdy_c = grant_val &&  grant_idx && mul_req.rdy;
      end
      STATE_WAIT: begin
        // Response steered to the owner; backpressure flows straight through
        resp0_val_c    = !owner_reg && mul_resp.val;
        resp1_val_c    =  owner_reg && mul_resp.val;
        resp0_msg_c    = owner_reg ? '0 : mul_resp.msg;
        resp1_msg_c    = owner_reg ? mul_resp.msg : '0;
        mul_resp_rdy_c = owner_rdy;
      end
      default: begin
        req0_rdy_c     = 1'bx;
        req1_rdy_c     = 1'bx;
        mul_req_val_c  = 1'bx;
        mul_req_msg_c  = 'x;
        resp0_val_c    = 1'bx;
        resp1_val_c    = 1'bx;
        resp0_msg_c    = 'x;
        resp1_msg_c    = 'x;
        mul_resp_rdy_c = 1'bx;
      end
    endcase
    if (reset) begin
      req0_rdy_c     = 1'b0;
      req1_rdy_c     = 1'b0;
      mul_req_val_c  = 1'b0;
      resp0_val_c    = 1'b0;
      resp1_val_c    = 1'b0;
      mul_resp_rdy_c = 1'b0;
    end
  end

  assign req0.rdy     = req0_rdy_c;
  assign req1.rdy     = req1_rdy_c;
  assign mul_req.val  = mul_req_val_c;
  assign mul_req.msg  = mul_req_msg_c;
  assign resp0.val    = resp0_val_c;
  assign resp0.msg    = resp0_msg_c;
  assign resp1.val    = resp1_val_c;
  assign resp1.msg    = resp1_msg_c;
  assign mul_resp.rdy = mul_resp_rdy_c;

  // Priority moves only when a response completes, so a stalled multiplier
  // cannot reorder who is favoured next.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= STATE_IDLE;
      owner_reg <= 1'b0;
      prio_reg  <= 1'b0;
    end else begin
      case (state_reg)
        STATE_IDLE: begin
          if (req_fire) begin
            owner_reg <= grant_idx;
            state_reg <= STATE_WAIT;
          end
        end
        STATE_WAIT: begin
          if (resp_fire) begin
            prio_reg  <= ~owner_reg;
            state_reg <= STATE_IDLE;
          end
        end
        default: state_reg <= STATE_IDLE;
      endcase
    end
  end

endmodule
